nibble_tx: RTL and testbench

//   Transmitter end of the x / x_is_valid nibble stream consumed by xpto.

---
 rtl/nibble_tx_pkg.sv | 23 ++
 rtl/nibble_tx_gapcnt.sv | 28 ++
 rtl/nibble_tx.sv | 112 +++++++++++
 tb/tb_nibble_tx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_tx_pkg.sv
// Shared definitions for the nibble_tx transmitter: nibble width, FSM
// state encoding and the word-width to nibble-count helper.
package nibble_tx_pkg;

   localparam int NIB_W = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_SEND = ST_SEND,
      S_GAP  = ST_GAP,
      S_DONE = ST_DONE
   } state_t;

   function automatic int nib_count(input int word_w);
      return word_w / NIB_W;
   endfunction

endpackage

// File: rtl/nibble_tx_gapcnt.sv
// Loadable 4-bit down-counter with a zero flag; times the idle gap
// between nibbles. Load wins over decrement; it saturates at zero.
module nibble_tx_gapcnt (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_load,
   input  logic [3:0] i_load_val,
   input  logic       i_dec,
   output logic       o_zero
);

   logic [3:0] r_cnt;

   // NOTE: sequential state always uses non-blocking (<=) so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= 4'd0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != 4'd0)) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   assign o_zero = (r_cnt == 4'd0);

endmodule

// File: rtl/nibble_tx.sv
// Nibble-stream transmitter: captures a word on start and emits it as
// WORD_W/4 strobed nibbles with GAP idle cycles between them.
module nibble_tx
   import nibble_tx_pkg::*;
#(
   parameter int WORD_W    = 16,
   parameter int GAP       = 0,
   parameter int MSB_FIRST = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WORD_W-1:0] data_in,
   output logic [NIB_W-1:0]  x,
   output logic              x_is_valid,
   output logic              busy,
   output logic              done
);

   localparam int              N        = nib_count(WORD_W);
   localparam int              NC_W     = (N > 1) ? $clog2(N) : 1;
   localparam logic [NC_W-1:0] NC_LOAD  = NC_W'(N - 1);
   localparam logic [3:0]      GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   state_t            r_state, w_state_nxt;
   logic [WORD_W-1:0] r_shift, w_shift_nxt;
   logic [NC_W-1:0]   r_nib_cnt, w_nib_cnt_nxt;
   logic [NIB_W-1:0]  r_x, w_nib_nxt;
   logic              r_valid, r_busy, r_done;
   logic              w_gap_load, w_gap_dec, w_gap_zero;

   nibble_tx_gapcnt u_gapcnt (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_gap_load),
      .i_load_val (GAP_LOAD),
      .i_dec      (w_gap_dec),
      .o_zero     (w_gap_zero)
   );

   // NOTE: every signal written here gets a default first, so no path
   // through the case can leave one unassigned and infer a latch.
   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_nib_cnt_nxt = r_nib_cnt;
      w_gap_load    = 1'b0;
      w_gap_dec     = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_shift_nxt   = data_in;
               w_nib_cnt_nxt = NC_LOAD;
               w_state_nxt   = S_SEND;
            end else begin
               w_state_nxt   = S_IDLE;
            end
         end
         S_SEND: begin
            w_shift_nxt = (MSB_FIRST != 0) ? (r_shift << NIB_W) : (r_shift >> NIB_W);
            if (r_nib_cnt == '0) begin
               w_state_nxt = S_DONE;
            end else begin
               w_nib_cnt_nxt = r_nib_cnt - 1'b1;
               if (GAP > 0) begin
                  w_gap_load  = 1'b1;
                  w_state_nxt = S_GAP;
               end else begin
                  w_state_nxt = S_SEND;
               end
            end
         end
         S_GAP: begin
            if (w_gap_zero) begin
               w_state_nxt = S_SEND;
            end else begin
               w_gap_dec   = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      // The nibble shown next cycle is the head of the next shift-register value.
      w_nib_nxt = (MSB_FIRST != 0) ? w_shift_nxt[WORD_W-1 -: NIB_W] : w_shift_nxt[NIB_W-1:0];
   end

   // Outputs are decoded from the next state so they come straight off flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_shift   <= '0;
         r_nib_cnt <= '0;
         r_x       <= '0;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_shift   <= w_shift_nxt;
         r_nib_cnt <= w_nib_cnt_nxt;
         r_x       <= (w_state_nxt == S_SEND) ? w_nib_nxt : '0;
         r_valid   <= (w_state_nxt == S_SEND);
         r_busy    <= (w_state_nxt == S_SEND) || (w_state_nxt == S_GAP);
         r_done    <= (w_state_nxt == S_DONE);
      end
   end

   assign x          = r_x;
   assign x_is_valid = r_valid;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule

// File: tb/tb_nibble_tx.sv
// Scoreboard bench for nibble_tx: four parameterisations share one clock,
// expected nibbles/done pulses are queued with their cycle, a monitor pops them.
module tb_nibble_tx;

   typedef struct {
      int         inst;
      bit         is_done;
      logic [3:0] nib;
      int         cyc;
      int         busy_len;
   } exp_t;

   // Instance configuration: 0 = W16/G0/MSB, 1 = W16/G2/MSB, 2 = W16/G0/LSB, 3 = W4/G0/MSB.
   int nn  [4] = '{4, 4, 4, 1};
   int gg  [4] = '{0, 2, 0, 0};
   int msb [4] = '{1, 1, 0, 1};

   logic        clk = 1'b0;
   logic        rst;
   logic        st   [4];
   logic [15:0] din  [3];
   logic [3:0]  din3;
   logic [3:0]  x_o  [4];
   logic        vld  [4];
   logic        bsy  [4];
   logic        dn   [4];

   int   cyc_n = 0;
   int   vectors = 0;
   int   miscompares = 0;
   int   busy_run [4] = '{0, 0, 0, 0};
   bit   mon_en = 1'b0;
   exp_t sbq [$];

   always #10 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   nibble_tx #(.WORD_W(16), .GAP(0), .MSB_FIRST(1)) u_dut0 (
      .clk(clk), .rst(rst), .start(st[0]), .data_in(din[0]),
      .x(x_o[0]), .x_is_valid(vld[0]), .busy(bsy[0]), .done(dn[0]));
   nibble_tx #(.WORD_W(16), .GAP(2), .MSB_FIRST(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(st[1]), .data_in(din[1]),
      .x(x_o[1]), .x_is_valid(vld[1]), .busy(bsy[1]), .done(dn[1]));
   nibble_tx #(.WORD_W(16), .GAP(0), .MSB_FIRST(0)) u_dut2 (
      .clk(clk), .rst(rst), .start(st[2]), .data_in(din[2]),
      .x(x_o[2]), .x_is_valid(vld[2]), .busy(bsy[2]), .done(dn[2]));
   nibble_tx #(.WORD_W(4), .GAP(0), .MSB_FIRST(1)) u_dut3 (
      .clk(clk), .rst(rst), .start(st[3]), .data_in(din3),
      .x(x_o[3]), .x_is_valid(vld[3]), .busy(bsy[3]), .done(dn[3]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Queue the expected nibbles (and done) of a frame whose first nibble shows at cycle e0.
   task automatic push_frame(input int i, input logic [15:0] d, input int e0, input int n_nib, input bit with_done);
      exp_t e;
      for (int k = 0; k < n_nib; k++) begin
         int pos;
         pos        = (msb[i] != 0) ? (nn[i] - 1 - k) : k;
         e.inst     = i;
         e.is_done  = 1'b0;
         e.nib      = d[pos*4 +: 4];
         e.cyc      = e0 + k * (gg[i] + 1);
         e.busy_len = 0;
         sbq.push_back(e);
      end
      if (with_done) begin
         e.inst     = i;
         e.is_done  = 1'b1;
         e.nib      = 4'h0;
         e.cyc      = e0 + (nn[i] - 1) * (gg[i] + 1) + 1;
         e.busy_len = nn[i] + (nn[i] - 1) * gg[i];
         sbq.push_back(e);
      end
   endtask

   task automatic set_start(input int i, input logic v, input logic [15:0] d);
      st[i] = v;
      if (i == 3) din3 = d[3:0];
      else        din[i] = d;
   endtask

   // Pulse start for one cycle and expect a complete frame.
   task automatic send_frame(input int i, input logic [15:0] d);
      set_start(i, 1'b1, d);
      push_frame(i, d, cyc_n + 1, nn[i], 1'b1);
      @(negedge clk);
      st[i] = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         for (int i = 0; i < 4; i++) begin
            int   idx;
            exp_t e;
            idx = -1;
            for (int k = 0; k < sbq.size(); k++)
               if (idx < 0 && sbq[k].inst == i) idx = k;
            if (vld[i] || dn[i]) begin
               vectors++;
               if (idx < 0) begin
                  miscompares++;
                  $display("FAIL unexpected_out inst%0d cyc %0d: valid=%0b x=%h done=%0b, expected no output",
                           i, cyc_n, vld[i], x_o[i], dn[i]);
               end else begin
                  e = sbq[idx];
                  sbq.delete(idx);
                  if (e.is_done) begin
                     if (!dn[i] || vld[i] || e.cyc != cyc_n || busy_run[i] != e.busy_len) begin
                        miscompares++;
                        $display("FAIL done inst%0d: got done=%0b valid=%0b cyc=%0d busy_len=%0d, expected done=1 valid=0 cyc=%0d busy_len=%0d",
                                 i, dn[i], vld[i], cyc_n, busy_run[i], e.cyc, e.busy_len);
                     end
                  end else begin
                     if (!vld[i] || x_o[i] !== e.nib || e.cyc != cyc_n) begin
                        miscompares++;
                        $display("FAIL nibble inst%0d: got valid=%0b x=%h cyc=%0d, expected valid=1 x=%h cyc=%0d",
                                 i, vld[i], x_o[i], cyc_n, e.nib, e.cyc);
                     end
                  end
               end
            end
            if (!vld[i] && x_o[i] !== 4'h0) begin
               miscompares++;
               $display("FAIL idle_x inst%0d cyc %0d: got x=%h, expected 0", i, cyc_n, x_o[i]);
            end
            if (dn[i] && bsy[i]) begin
               miscompares++;
               $display("FAIL done_busy inst%0d cyc %0d: got busy=1 with done, expected busy=0", i, cyc_n);
            end
            busy_run[i] = bsy[i] ? busy_run[i] + 1 : 0;
         end
         for (int k = sbq.size() - 1; k >= 0; k--) begin
            if (sbq[k].cyc < cyc_n) begin
               vectors++;
               miscompares++;
               $display("FAIL missing inst%0d: got nothing, expected %s x=%h at cyc %0d",
                        sbq[k].inst, sbq[k].is_done ? "done" : "nibble", sbq[k].nib, sbq[k].cyc);
               sbq.delete(k);
            end
         end
      end
   end

   initial begin
      int c;
      rst = 1'b1;
      din3 = 4'h0;
      for (int i = 0; i < 4; i++) st[i] = 1'b0;
      for (int i = 0; i < 3; i++) din[i] = 16'h0;
      @(negedge clk);
      for (int i = 0; i < 4; i++)
         check($sformatf("reset_outputs_inst%0d", i), {25'd0, x_o[i], vld[i], bsy[i], dn[i]}, 32'd0);
      rst = 1'b0;
      mon_en = 1'b1;
      tick(1);

      // Back-to-back nibbles, MSB first.
      send_frame(0, 16'h5A3C);
      tick(8);

      // Two idle cycles between nibbles.
      send_frame(1, 16'h5A3C);
      tick(14);

      // LSB first; start and data_in changes mid-frame are ignored.
      set_start(2, 1'b1, 16'h5A3C);
      push_frame(2, 16'h5A3C, cyc_n + 1, 4, 1'b1);
      @(negedge clk);
      set_start(2, 1'b0, 16'hFFFF);
      @(negedge clk);
      set_start(2, 1'b1, 16'hFFFF);
      check("busy_during_ignored_start", {31'd0, bsy[2]}, 32'd1);
      @(negedge clk);
      set_start(2, 1'b0, 16'hFFFF);
      tick(6);

      // Reset after the second nibble aborts the frame with no done.
      set_start(0, 1'b1, 16'h5A3C);
      push_frame(0, 16'h5A3C, cyc_n + 1, 2, 1'b0);
      @(negedge clk);
      st[0] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_outputs_zero", {25'd0, x_o[0], vld[0], bsy[0], dn[0]}, 32'd0);
      rst = 1'b0;
      tick(2);
      send_frame(0, 16'h1234);
      tick(8);

      // Start held through done: second frame follows done with no idle cycle.
      c = cyc_n;
      set_start(0, 1'b1, 16'h0F0F);
      push_frame(0, 16'h0F0F, c + 1, 4, 1'b1);
      push_frame(0, 16'hA5A5, c + 6, 4, 1'b1);
      @(negedge clk);
      din[0] = 16'hA5A5;
      tick(4);
      check("b2b_done_pulse", {31'd0, dn[0]}, 32'd1);
      @(negedge clk);
      st[0] = 1'b0;
      tick(8);

      // Single-nibble word feeding the xpto input.
      send_frame(3, 16'h0005);
      tick(6);

      begin
         int budget;
         budget = 50;
         while (sbq.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
         end
         if (sbq.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending items, expected 0", sbq.size());
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
